// File: rtl/button_encoder.sv
// ---------------------------------------------------------------------------
// button_encoder
//
// Front end for the game controller's player input port. Each of the four raw
// colour buttons is synchronised, then debounced. Every accepted press of a
// single button is encoded into a 2-bit colour code with a one-cycle valid
// strobe. Chords and presses made while disabled are rejected. The next press
// is only accepted after all buttons have been fully released.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronised cycles needed before a
//                     level change is accepted (>= 2)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES-1
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous, active-low reset
//   btn       : raw buttons, active high, asynchronous to clk; btn[k] = colour k
//   enable    : 1 while the controller is in its input phase
//   btn_code  : colour code of the last accepted press
//   btn_valid : one-cycle strobe, btn_code holds a new press
//   btn_held  : 1 while an accepted or rejected press is still held down
//   btn_chord : one-cycle strobe, several buttons were debounced high together
// ---------------------------------------------------------------------------
module button_encoder #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       enable,
    output logic [1:0] btn_code,
    output logic       btn_valid,
    output logic       btn_held,
    output logic       btn_chord
);

    typedef enum logic {
        IDLE_S = 1'b0,
        HOLD_S = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_meta;
    logic [3:0]       sync_s;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];

    logic [2:0]       db_count;
    logic [1:0]       db_index;

    state_t           state;
    state_t           state_next;
    logic [1:0]       code_next;
    logic             valid_next;
    logic             chord_next;

    // Two-flop synchroniser followed by a per-bit debounce counter. A bit's
    // debounced level only follows its synchronised level after the two have
    // disagreed on DEBOUNCE_CYCLES consecutive edges; a single cycle of
    // agreement restarts the count, so bounces never get through. The counter
    // is cleared whenever it would otherwise reach its limit, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_s    <= '0;
            db        <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync_meta <= btn;
            sync_s    <= sync_meta;
            for (int k = 0; k < 4; k++) begin
                if (sync_s[k] == db[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    db[k]  <= sync_s[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Number of debounced buttons currently down, and the colour index that
    // applies when exactly one of them is down.
    always_comb begin
        db_count = 3'(db[0]) + 3'(db[1]) + 3'(db[2]) + 3'(db[3]);
        db_index = 2'd0;
        case (db)
            4'b0010: db_index = 2'd1;
            4'b0100: db_index = 2'd2;
            4'b1000: db_index = 2'd3;
            default: db_index = 2'd0;
        endcase
    end

    // Press FSM. IDLE_S waits for the first debounced press and classifies it
    // as a single press (strobed only when enabled) or a chord. HOLD_S ignores
    // everything until every button has been released, which is what enforces
    // one strobe per press and lets the first button win an overlap.
    always_comb begin
        state_next = state;
        code_next  = btn_code;
        valid_next = 1'b0;
        chord_next = 1'b0;
        case (state)
            IDLE_S: begin
                if (db_count == 3'd1) begin
                    state_next = HOLD_S;
                    if (enable) begin
                        valid_next = 1'b1;
                        code_next  = db_index;
                    end
                end else if (db_count >= 3'd2) begin
                    state_next = HOLD_S;
                    chord_next = 1'b1;
                end
            end
            HOLD_S: begin
                if (db == 4'b0000) begin
                    state_next = IDLE_S;
                end
            end
            default: state_next = IDLE_S;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE_S;
            btn_code  <= 2'd0;
            btn_valid <= 1'b0;
            btn_chord <= 1'b0;
        end else begin
            state     <= state_next;
            btn_code  <= code_next;
            btn_valid <= valid_next;
            btn_chord <= chord_next;
        end
    end

    assign btn_held = (state == HOLD_S);

endmodule

// File: tb/tb_button_encoder.sv
// ---------------------------------------------------------------------------
// tb_button_encoder
//
// Self-checking bench for button_encoder with DEBOUNCE_CYCLES = 4. A
// behavioural reference model predicts every output cycle by cycle. Each
// scenario task also checks its own strobe counts, codes and strobe timing
// against fixed expectations.
// ---------------------------------------------------------------------------
module tb_button_encoder;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       enable;
    logic [1:0] btn_code;
    logic       btn_valid;
    logic       btn_held;
    logic       btn_chord;

    int total;
    int bad;

    button_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .enable   (enable),
        .btn_code (btn_code),
        .btn_valid(btn_valid),
        .btn_held (btn_held),
        .btn_chord(btn_chord)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. The raw input travels through a two-stage delay line.
    // A button's clean level changes once the delayed level has disagreed with
    // it for D edges in a row. The press logic reacts to the previous clean
    // levels: it is either waiting for a press or waiting for a full release.
    logic [3:0] mMeta;
    logic [3:0] mS;
    logic [3:0] mDb;
    int         mRun [4];
    logic       mHeld;
    logic       mValid;
    logic       mChord;
    logic [1:0] mCode;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMeta = '0;
            mS = '0;
            mDb = '0;
            for (int k = 0; k < 4; k++) mRun[k] = 0;
            mHeld = 1'b0;
            mValid = 1'b0;
            mChord = 1'b0;
            mCode = 2'd0;
        end else begin
            int down;
            down = 0;
            for (int k = 0; k < 4; k++) down += int'(mDb[k]);
            mValid = 1'b0;
            mChord = 1'b0;
            if (!mHeld) begin
                if (down == 1) begin
                    mHeld = 1'b1;
                    if (enable) begin
                        mValid = 1'b1;
                        for (int k = 0; k < 4; k++)
                            if (mDb[k]) mCode = 2'(k);
                    end
                end else if (down >= 2) begin
                    mHeld = 1'b1;
                    mChord = 1'b1;
                end
            end else if (down == 0) begin
                mHeld = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (mS[k] != mDb[k]) begin
                    mRun[k]++;
                    if (mRun[k] == D) begin
                        mDb[k] = mS[k];
                        mRun[k] = 0;
                    end
                end else begin
                    mRun[k] = 0;
                end
            end
            mS = mMeta;
            mMeta = btn;
        end
    end

    logic [4:0] dutVec;
    logic [4:0] modelVec;
    assign dutVec   = {btn_code, btn_valid, btn_held, btn_chord};
    assign modelVec = {mCode, mValid, mHeld, mChord};

    task automatic test_reset();
        rst_n = 1'b0;
        btn = 4'b0000;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (dutVec !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_state: got %b want %b", dutVec, 5'b00000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (dutVec !== 5'b00000) begin
                bad++;
                $display("[TB] FAIL reset_idle: got %b want %b", dutVec, 5'b00000);
            end
        end
    endtask

    task automatic test_clean_press();
        int nValid, validEdge, lastCode, dropEdge;
        nValid = 0; validEdge = -1; lastCode = -1; dropEdge = -1;
        btn = 4'b0100;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL clean_model: edge %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) begin nValid++; validEdge = i; lastCode = int'(btn_code); end
        end
        btn = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL clean_release_model: edge %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) nValid++;
            if (btn_held === 1'b0 && dropEdge < 0) dropEdge = i;
        end
        total++;
        if (nValid != 1 || validEdge != 7 || lastCode != 2) begin
            bad++;
            $display("[TB] FAIL clean_strobe: got count=%0d edge=%0d code=%0d want count=1 edge=7 code=2",
                     nValid, validEdge, lastCode);
        end
        total++;
        if (dropEdge != 7) begin
            bad++;
            $display("[TB] FAIL clean_held_drop: got edge %0d want 7", dropEdge);
        end
    endtask

    task automatic test_bounce();
        int nValid, validEdge, lastCode;
        nValid = 0; validEdge = -1; lastCode = -1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                btn = (i < 3) ? 4'b0010 : 4'b0000;
                @(negedge clk);
                total++;
                if (dutVec !== modelVec) begin
                    bad++;
                    $display("[TB] FAIL bounce_model: got %b want %b", dutVec, modelVec);
                end
                if (btn_valid === 1'b1) nValid++;
            end
        end
        total++;
        if (nValid != 0) begin
            bad++;
            $display("[TB] FAIL bounce_no_strobe: got %0d strobes want 0", nValid);
        end
        btn = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL bounce_steady_model: edge %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) begin nValid++; validEdge = i; lastCode = int'(btn_code); end
        end
        total++;
        if (nValid != 1 || validEdge != 7 || lastCode != 1) begin
            bad++;
            $display("[TB] FAIL bounce_strobe: got count=%0d edge=%0d code=%0d want count=1 edge=7 code=1",
                     nValid, validEdge, lastCode);
        end
        btn = 4'b0000;
        repeat (12) @(negedge clk);
        total++;
        if (btn_held !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bounce_release: held got %b want 0", btn_held);
        end
    endtask

    task automatic test_chord();
        int nValid, nChord, lastCode;
        nValid = 0; nChord = 0; lastCode = -1;
        btn = 4'b0011;
        for (int i = 1; i <= 24; i++) begin
            if (i == 13) btn = 4'b0000;
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL chord_model: cycle %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) nValid++;
            if (btn_chord === 1'b1) nChord++;
        end
        total++;
        if (nChord != 1 || nValid != 0) begin
            bad++;
            $display("[TB] FAIL chord_pulse: got chord=%0d valid=%0d want chord=1 valid=0", nChord, nValid);
        end
        btn = 4'b1000;
        for (int i = 1; i <= 24; i++) begin
            if (i == 13) btn = 4'b0000;
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL chord_after_model: cycle %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) begin nValid++; lastCode = int'(btn_code); end
        end
        total++;
        if (nValid != 1 || lastCode != 3) begin
            bad++;
            $display("[TB] FAIL chord_then_single: got count=%0d code=%0d want count=1 code=3", nValid, lastCode);
        end
    endtask

    task automatic test_disabled();
        int nValid, lastCode;
        nValid = 0; lastCode = -1;
        enable = 1'b0;
        btn = 4'b0001;
        for (int i = 1; i <= 18; i++) begin
            if (i == 13) enable = 1'b1;
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL disabled_model: cycle %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) nValid++;
        end
        total++;
        if (nValid != 0 || btn_held !== 1'b1) begin
            bad++;
            $display("[TB] FAIL disabled_silent: got count=%0d held=%b want count=0 held=1", nValid, btn_held);
        end
        btn = 4'b0000;
        repeat (12) @(negedge clk);
        btn = 4'b0001;
        for (int i = 1; i <= 24; i++) begin
            if (i == 13) btn = 4'b0000;
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL disabled_repress_model: cycle %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) begin nValid++; lastCode = int'(btn_code); end
        end
        total++;
        if (nValid != 1 || lastCode != 0) begin
            bad++;
            $display("[TB] FAIL disabled_repress: got count=%0d code=%0d want count=1 code=0", nValid, lastCode);
        end
    endtask

    task automatic test_overlap();
        int nValid;
        nValid = 0;
        btn = 4'b0100;
        for (int i = 1; i <= 36; i++) begin
            if (i == 13) btn = 4'b1100;
            if (i == 25) btn = 4'b0000;
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL overlap_model: cycle %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) nValid++;
        end
        total++;
        if (nValid != 1 || btn_held !== 1'b0 || btn_code !== 2'd2) begin
            bad++;
            $display("[TB] FAIL overlap_single: got count=%0d held=%b code=%0d want count=1 held=0 code=2",
                     nValid, btn_held, btn_code);
        end
    endtask

    task automatic test_reset_mid_hold();
        int nValid, validEdge, lastCode;
        nValid = 0; validEdge = -1; lastCode = -1;
        btn = 4'b0010;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (dutVec !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_mid_hold: got %b want %b", dutVec, 5'b00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL reset_mid_hold_model: edge %0d got %b want %b", i, dutVec, modelVec);
            end
            if (btn_valid === 1'b1) begin nValid++; validEdge = i; lastCode = int'(btn_code); end
        end
        total++;
        if (nValid != 1 || validEdge != 7 || lastCode != 1) begin
            bad++;
            $display("[TB] FAIL reset_mid_hold_strobe: got count=%0d edge=%0d code=%0d want count=1 edge=7 code=1",
                     nValid, validEdge, lastCode);
        end
        btn = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        int left;
        left = 0;
        for (int i = 0; i < 600; i++) begin
            if (left == 0) begin
                if ($urandom_range(0, 3) == 0)
                    btn = 4'($urandom_range(0, 15));
                else if ($urandom_range(0, 1) == 0)
                    btn = 4'b0001 << $urandom_range(0, 3);
                else
                    btn = 4'b0000;
                enable = ($urandom_range(0, 4) != 0);
                left = int'($urandom_range(1, 10));
            end
            left--;
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL random_model: cycle %0d btn=%b got %b want %b", i, btn, dutVec, modelVec);
            end
        end
        btn = 4'b0000;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (dutVec !== modelVec) begin
                bad++;
                $display("[TB] FAIL random_drain_model: got %b want %b", dutVec, modelVec);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_chord();
        test_disabled();
        test_overlap();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
